// File: rtl/vx_raster_stamp_packer_pkg.sv
// Shared raster types: the per-stamp record and the stamp packer state encoding.
// Used by vx_raster_stamp_packer (optional idle flush via RASTER_PACK_TIMEOUT_EN).
package vx_raster_stamp_packer_pkg;

  localparam int unsigned POS_W  = 10;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned PID_W  = 8;

  // A zero coverage mask marks an empty stamp.
  typedef struct packed {
    logic [POS_W-1:0]  pos_x;
    logic [POS_W-1:0]  pos_y;
    logic [MASK_W-1:0] mask;
    logic [PID_W-1:0]  pid;
  } raster_stamp_t;

  localparam int unsigned STAMP_W = $bits(raster_stamp_t);

  typedef enum logic [1:0] {
    PACK_FILL = 2'd0,
    PACK_SEND = 2'd1,
    PACK_DONE = 2'd2
  } pack_state_e;

endpackage

// File: rtl/vx_raster_stamp_packer.sv
// Packs single stamps into NUM_LANES-wide raster requests and appends the sticky done flag.
// Define RASTER_PACK_TIMEOUT_EN to flush partial bundles after TIMEOUT idle cycles.
module vx_raster_stamp_packer
  import vx_raster_stamp_packer_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           stamp_valid,
  input  logic [STAMP_W-1:0]             stamp_in,
  output logic                           stamp_ready,
  input  logic                           done_in,
  output logic                           req_out_valid,
  output logic [NUM_LANES*STAMP_W-1:0]   req_out_stamps,
  output logic                           req_out_done,
  input  logic                           req_out_ready
);

  localparam int unsigned CNT_W = $clog2(NUM_LANES + 1);

  pack_state_e          state_q, state_d;
  logic [STAMP_W-1:0]   lanes_q [NUM_LANES];
  logic [CNT_W-1:0]     count_q, count_d, count_inc;
  logic                 done_q, done_d;
  logic                 fill_hs;
  logic                 full_next;
  logic                 flush_timeout;
  logic [NUM_LANES-1:0] lane_we;

  assign fill_hs   = (state_q == PACK_FILL) && stamp_valid;
  assign count_inc = count_q + CNT_W'(1);
  assign full_next = (count_inc == CNT_W'(NUM_LANES));

`ifdef RASTER_PACK_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              idle_cycle;

  assign idle_cycle = (state_q == PACK_FILL) && (count_q != '0) && !stamp_valid;

  // idle_d counts the current idle cycle, so the flush decision lands on the TIMEOUT-th one.
  always_comb begin
    idle_d = '0;
    if (idle_cycle) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  assign flush_timeout = idle_cycle && (idle_d == IDLE_W'(TIMEOUT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  // Without the idle flush a partial bundle waits for more stamps or done_in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign flush_timeout      = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PACK_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; an offered stamp wins over done_in so it lands in the final bundle
  always_comb begin
    state_d = state_q;
    case (state_q)
      PACK_FILL: begin
        if (stamp_valid) begin
          if (full_next) begin
            state_d = PACK_SEND;
          end
        end else if (done_in || flush_timeout) begin
          state_d = PACK_SEND;
        end
      end
      PACK_SEND: begin
        if (req_out_ready) begin
          state_d = done_q ? PACK_DONE : PACK_FILL;
        end
      end
      PACK_DONE: begin
        if (!done_in) begin
          state_d = PACK_FILL;
        end
      end
      default: state_d = PACK_FILL;
    endcase
  end

  // FSM: outputs
  always_comb begin
    stamp_ready   = 1'b0;
    req_out_valid = 1'b0;
    req_out_done  = 1'b0;
    case (state_q)
      PACK_FILL: stamp_ready = 1'b1;
      PACK_SEND: begin
        req_out_valid = 1'b1;
        req_out_done  = done_q;
      end
      // Held high so the downstream AND of all slices' done stays true.
      PACK_DONE: req_out_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    case (state_q)
      PACK_FILL: begin
        if (stamp_valid) begin
          count_d = count_inc;
        end else if (done_in) begin
          done_d = 1'b1;
        end
      end
      PACK_SEND: begin
        if (req_out_ready) begin
          count_d = '0;
        end
      end
      PACK_DONE: begin
        if (!done_in) begin
          done_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    lane_we = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_we[i] = fill_hs && (count_q == CNT_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        lanes_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_we[i]) begin
          lanes_q[i] <= stamp_in;
        end
      end
    end
  end

  // Lanes past count may hold stale stamps from an earlier bundle; send them as empty.
  always_comb begin
    req_out_stamps = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (CNT_W'(i) < count_q) begin
        req_out_stamps[i*STAMP_W +: STAMP_W] = lanes_q[i];
      end
    end
  end

endmodule
